// File: rtl/raw_readback_serialiser.sv
// Read-back serialiser: buffers 24-bit SDRAM sample words in a small FIFO and
// streams each word MSB-first as three bytes to the SPI register interface.
module raw_readback_serialiser #(
    parameter int unsigned ABITS = 2,
    parameter int unsigned DELAY = 3
) (
    input  logic             clock_i,
    input  logic             reset_ni,
    input  logic             enable_i,
    input  logic             mem_valid_i,
    input  logic [31:0]      mem_data_i,
    input  logic             byte_req_i,
    output logic [7:0]       byte_data_o,
    output logic             byte_valid_o,
    output logic             read_complete_o,
    output logic [ABITS:0]   words_o,
    output logic             overflow_o
);
    localparam int unsigned DEPTH = 1 << ABITS;
    localparam int unsigned PW    = ABITS + 1;
    localparam int unsigned WW    = 24;

    typedef enum logic {S_EMPTY, S_SEND} state_t;

    state_t          state_q, state_d;
    logic [WW-1:0]   mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   words_q, words_d;
    logic [WW-1:0]   word_q, word_d;
    logic [1:0]      idx_q, idx_d;
    logic [7:0]      byte_q, byte_d;
    logic            valid_q, valid_d;
    logic            done_q, done_d;
    logic            ovf_q, ovf_d;
    logic            empty_c, full_c, push_c, pop_c, push_ok_c;
    logic            unused_c;

    // The simulation delay parameter and the upper data byte carry no logic.
    assign unused_c = ^{mem_data_i[31:WW], 32'(DELAY)};

    assign empty_c = (wr_ptr_q == rd_ptr_q);
    assign full_c  = (wr_ptr_q[ABITS] != rd_ptr_q[ABITS]) &&
                     (wr_ptr_q[ABITS-1:0] == rd_ptr_q[ABITS-1:0]);

    // Next-state: serialiser sequencing, FIFO pointer update and byte select.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        word_d    = word_q;
        pop_c     = 1'b0;
        done_d    = 1'b0;
        push_c    = enable_i && mem_valid_i;
        push_ok_c = 1'b0;
        ovf_d     = ovf_q;
        byte_d    = 8'h00;

        case (state_q)
            S_EMPTY: begin
                if (!empty_c) begin
                    pop_c   = 1'b1;
                    word_d  = mem_q[rd_ptr_q[ABITS-1:0]];
                    idx_d   = 2'd0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (byte_req_i) begin
                    if (idx_q != 2'd2) begin
                        idx_d = idx_q + 2'd1;
                    end else begin
                        done_d = 1'b1;
                        idx_d  = 2'd0;
                        if (!empty_c) begin
                            pop_c  = 1'b1;
                            word_d = mem_q[rd_ptr_q[ABITS-1:0]];
                        end else begin
                            state_d = S_EMPTY;
                        end
                    end
                end
            end
        endcase

        // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
        push_ok_c = push_c && (!full_c || pop_c);
        ovf_d     = ovf_q | (push_c && !push_ok_c);
        wr_ptr_d  = wr_ptr_q + PW'(push_ok_c);
        rd_ptr_d  = rd_ptr_q + PW'(pop_c);
        words_d   = wr_ptr_d - rd_ptr_d;
        valid_d   = (state_d == S_SEND);

        if (valid_d) begin
            case (idx_d)
                2'd0:    byte_d = word_d[23:16];
                2'd1:    byte_d = word_d[15:8];
                default: byte_d = word_d[7:0];
            endcase
        end
    end

    // State and control registers.
    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            state_q  <= S_EMPTY;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            words_q  <= '0;
            word_q   <= '0;
            idx_q    <= 2'd0;
            byte_q   <= 8'h00;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            words_q  <= words_d;
            word_q   <= word_d;
            idx_q    <= idx_d;
            byte_q   <= byte_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
        end
    end

    // FIFO storage; contents are don't-care until the write pointer passes them.
    always_ff @(posedge clock_i) begin
        if (push_ok_c) begin
            mem_q[wr_ptr_q[ABITS-1:0]] <= mem_data_i[WW-1:0];
        end
    end

    assign byte_data_o     = byte_q;
    assign byte_valid_o    = valid_q;
    assign read_complete_o = done_q;
    assign words_o         = words_q;
    assign overflow_o      = ovf_q;
endmodule
